mips_trace_sequencer: RTL and testbench

//   Synthesisable successor to the MIPS bench harness: sequences the core's reset
//   and records a triggered trace of the core's bus outputs (direccion, palabra,

---
 rtl/mips_trace_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mips_trace_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_sequencer.sv
// mips_trace_sequencer
// Holds the MIPS core in reset for a fixed pulse after system reset, then waits
// for an address trigger on the core's bus taps, captures DEPTH consecutive bus
// snapshots {direccion, palabra, leer_dato} and drains them oldest-first over a
// valid/ready port. Emptying the buffer re-arms the trigger.
module mips_trace_sequencer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int RST_PULSE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      cpu_rst,
    input  logic [DATA_W-1:0]         direccion,
    input  logic [DATA_W-1:0]         palabra,
    input  logic [DATA_W-1:0]         leer_dato,
    input  logic                      trig_en,
    input  logic [DATA_W-1:0]         trig_addr,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [3*DATA_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [PC_W-1:0]      pulse_cnt_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_s;
    logic [CNT_W-1:0]     count_r;
    logic [3*DATA_W-1:0]  mem_r [DEPTH];
    logic [3*DATA_W-1:0]  rd_data_r;
    logic                 cpu_rst_r;
    logic                 done_r;
    logic                 rd_valid_r;
    logic                 trig_s;
    logic                 wr_s;
    logic                 pop_s;
    logic                 cpu_rst_s;
    logic                 done_s;
    logic                 rd_valid_s;

    assign cpu_rst  = cpu_rst_r;
    assign done     = done_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign count    = count_r;

    // Trigger match, write strobe (never when full) and consumer pop strobe.
    always_comb begin
        trig_s = trig_en && (direccion == trig_addr);
        wr_s   = ((state_r == ST_ARMED) && trig_s) ||
                 ((state_r == ST_CAPTURE) && (count_r != CNT_FULL));
        pop_s  = (state_r == ST_DONE) && rd_valid_r && rd_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HOLD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: the write that fills the buffer and the pop that empties it
    // both change state on that same edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_HOLD: begin
                if (pulse_cnt_r == PULSE_LAST) state_s = ST_ARMED;
                else                           state_s = ST_HOLD;
            end
            ST_ARMED: begin
                if (trig_s) state_s = ST_CAPTURE;
                else        state_s = ST_ARMED;
            end
            ST_CAPTURE: begin
                if (count_r == CNT_LAST) state_s = ST_DONE;
                else                     state_s = ST_CAPTURE;
            end
            ST_DONE: begin
                if (pop_s && (count_r == CNT_ONE)) state_s = ST_ARMED;
                else                               state_s = ST_DONE;
            end
            default: state_s = ST_HOLD;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        cpu_rst_s  = (state_s == ST_HOLD);
        done_s     = (state_s == ST_DONE);
        rd_valid_s = (state_s == ST_DONE);
        if (pop_s) rd_ptr_s = rd_ptr_r + PTR_W'(1);
        else       rd_ptr_s = rd_ptr_r;
    end

    // Core reset pulse counter: counts cycles spent in HOLD once rst is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt_r <= {PC_W{1'b0}};
        end else if (state_r == ST_HOLD) begin
            pulse_cnt_r <= pulse_cnt_r + PC_W'(1);
        end else begin
            pulse_cnt_r <= {PC_W{1'b0}};
        end
    end

    // Pointers, occupancy and registered outputs; read data is prefetched from the
    // next read pointer so it is valid alongside rd_valid and frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {(3*DATA_W){1'b0}};
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else      wr_ptr_r <= wr_ptr_r;
            rd_ptr_r <= rd_ptr_s;
            if (wr_s)       count_r <= count_r + CNT_ONE;
            else if (pop_s) count_r <= count_r - CNT_ONE;
            else            count_r <= count_r;
            cpu_rst_r  <= cpu_rst_s;
            done_r     <= done_s;
            rd_valid_r <= rd_valid_s;
            if (state_s == ST_DONE) rd_data_r <= mem_r[rd_ptr_s];
            else                    rd_data_r <= {(3*DATA_W){1'b0}};
        end
    end

    // Trace storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {direccion, palabra, leer_dato};
        end
    end

endmodule

// File: tb/tb_mips_trace_sequencer.sv
// Directed bench for mips_trace_sequencer: a default build (32-bit, 16 deep,
// 4-cycle pulse) and a small build (16-bit, 4 deep, 2-cycle pulse).
module tb_mips_trace_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cpu_rst, trig_en, rd_valid, rd_ready, done;
    logic [31:0] direccion, palabra, leer_dato, trig_addr;
    logic [95:0] rd_data;
    logic [4:0]  count;

    logic        s_rst, s_cpu_rst, s_trig_en, s_rd_valid, s_rd_ready, s_done;
    logic [15:0] s_dir, s_pal, s_leer, s_trig_addr;
    logic [47:0] s_rd_data;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    mips_trace_sequencer #(.DATA_W(32), .DEPTH(16), .RST_PULSE(4)) dut (
        .clk(clk), .rst(rst), .cpu_rst(cpu_rst),
        .direccion(direccion), .palabra(palabra), .leer_dato(leer_dato),
        .trig_en(trig_en), .trig_addr(trig_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .done(done)
    );

    mips_trace_sequencer #(.DATA_W(16), .DEPTH(4), .RST_PULSE(2)) dut_small (
        .clk(clk), .rst(s_rst), .cpu_rst(s_cpu_rst),
        .direccion(s_dir), .palabra(s_pal), .leer_dato(s_leer),
        .trig_en(s_trig_en), .trig_addr(s_trig_addr),
        .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data),
        .count(s_count), .done(s_done)
    );

    function automatic logic [95:0] exp_entry(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_0000};
    endfunction

    task automatic drive_bus(input logic [31:0] a);
        direccion = a;
        palabra   = ~a;
        leer_dato = a ^ 32'hA5A5_0000;
    endtask

    task automatic test_reset;
        logic exp_b;
        rst = 1'b1; trig_en = 1'b0; rd_ready = 1'b0; trig_addr = 32'h0;
        drive_bus(32'h0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cpu_rst, done, rd_valid, count, rd_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 96'd0}) begin
            n_fail++;
            $display("FAIL reset_state got cpu_rst=%b done=%b rd_valid=%b count=%0d rd_data=%h",
                     cpu_rst, done, rd_valid, count, rd_data);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_b = (k < 4) ? 1'b1 : 1'b0;
            n_checks++;
            if (cpu_rst !== exp_b) begin
                n_fail++;
                $display("FAIL reset_pulse k=%0d got cpu_rst=%b exp=%b", k, cpu_rst, exp_b);
            end
        end
        n_checks++;
        if ({count, done, rd_valid} !== {5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL armed_idle got count=%0d done=%b rd_valid=%b", count, done, rd_valid);
        end
    endtask

    task automatic test_capture;
        logic [4:0] exp_cnt;
        logic       exp_done;
        trig_addr = 32'h40;
        trig_en   = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            if (j >= 5) begin
                exp_cnt  = 5'(j - 4);
                exp_done = (j >= 20) ? 1'b1 : 1'b0;
                n_checks++;
                if ({count, done, rd_valid} !== {exp_cnt, exp_done, exp_done}) begin
                    n_fail++;
                    $display("FAIL capture j=%0d got count=%0d done=%b rd_valid=%b exp count=%0d done=%b",
                             j, count, done, rd_valid, exp_cnt, exp_done);
                end
            end else if (j >= 1) begin
                n_checks++;
                if (count !== 5'd0) begin
                    n_fail++;
                    $display("FAIL pre_trigger j=%0d got count=%0d exp=0", j, count);
                end
            end
            drive_bus(32'h30 + 32'(4 * j));
        end
        trig_en = 1'b0;
    endtask

    task automatic test_drain;
        int         e;
        logic [4:0] exp_cnt;
        e = 0;
        for (int cyc = 0; cyc < 40 && e < 16; cyc++) begin
            if (cyc != 0) @(negedge clk);
            exp_cnt = 5'(16 - e);
            n_checks++;
            if ({rd_valid, done, count, rd_data} !== {1'b1, 1'b1, exp_cnt, exp_entry(32'h40 + 32'(4 * e))}) begin
                n_fail++;
                $display("FAIL drain cyc=%0d entry=%0d got valid=%b done=%b count=%0d data=%h exp data=%h",
                         cyc, e, rd_valid, done, count, rd_data, exp_entry(32'h40 + 32'(4 * e)));
            end
            rd_ready = (cyc % 2 == 0) ? 1'b1 : 1'b0;
            if (rd_ready) e++;
        end
        if (e != 16) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout got entries=%0d exp=16", e);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        n_checks++;
        if ({rd_valid, done, count, cpu_rst} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_empty got valid=%b done=%b count=%0d cpu_rst=%b",
                     rd_valid, done, count, cpu_rst);
        end
    endtask

    task automatic test_no_trigger;
        trig_addr = 32'h100;
        drive_bus(32'h100);
        trig_en  = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_checks++;
            if ({count, done, rd_valid} !== {5'd0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL no_trigger k=%0d got count=%0d done=%b rd_valid=%b", k, count, done, rd_valid);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_capture;
        logic exp_b;
        trig_addr = 32'h200;
        drive_bus(32'h200);
        trig_en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            trig_en = 1'b0;
            n_checks++;
            if ({count, done} !== {5'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL mid_capture k=%0d got count=%0d done=%b", k, count, done);
            end
            drive_bus(32'h200 + 32'(4 * k));
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_rst, done, rd_valid, count, rd_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 96'd0}) begin
            n_fail++;
            $display("FAIL mid_reset got cpu_rst=%b done=%b rd_valid=%b count=%0d", cpu_rst, done, rd_valid, count);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_b = (k < 4) ? 1'b1 : 1'b0;
            n_checks++;
            if ({cpu_rst, count} !== {exp_b, 5'd0}) begin
                n_fail++;
                $display("FAIL mid_reset_pulse k=%0d got cpu_rst=%b count=%0d exp cpu_rst=%b", k, cpu_rst, count, exp_b);
            end
        end
    endtask

    task automatic test_small_build;
        logic [15:0] e_dir, e_pal;
        logic [47:0] e_data;
        n_checks++;
        if ({s_cpu_rst, s_rd_data, s_count} !== {1'b1, 48'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL small_reset got cpu_rst=%b data=%h count=%0d", s_cpu_rst, s_rd_data, s_count);
        end
        s_rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL small_pulse_hi got cpu_rst=%b exp=1", s_cpu_rst);
        end
        @(negedge clk);
        n_checks++;
        if (s_cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL small_pulse_lo got cpu_rst=%b exp=0", s_cpu_rst);
        end
        s_trig_addr = 16'h0010;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k > 0) begin
                    n_checks++;
                    if ({s_count, s_done} !== {3'(k), 1'b0}) begin
                        n_fail++;
                        $display("FAIL small_capture r=%0d k=%0d got count=%0d done=%b", r, k, s_count, s_done);
                    end
                end
                s_trig_en = (k == 0) ? 1'b1 : 1'b0;
                s_dir  = 16'h0010 + 16'(k);
                s_pal  = 16'(r * 16 + k);
                s_leer = ~s_pal;
            end
            @(negedge clk);
            s_trig_en = 1'b0;
            n_checks++;
            if ({s_count, s_done, s_rd_valid} !== {3'd4, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL small_full r=%0d got count=%0d done=%b valid=%b", r, s_count, s_done, s_rd_valid);
            end
            for (int e = 0; e < 4; e++) begin
                if (e > 0) @(negedge clk);
                e_dir  = 16'h0010 + 16'(e);
                e_pal  = 16'(r * 16 + e);
                e_data = {e_dir, e_pal, ~e_pal};
                n_checks++;
                if ({s_rd_valid, s_count, s_rd_data} !== {1'b1, 3'(4 - e), e_data}) begin
                    n_fail++;
                    $display("FAIL small_drain r=%0d e=%0d got valid=%b count=%0d data=%h exp=%h",
                             r, e, s_rd_valid, s_count, s_rd_data, e_data);
                end
                s_rd_ready = 1'b1;
            end
            @(negedge clk);
            s_rd_ready = 1'b0;
            n_checks++;
            if ({s_rd_valid, s_done, s_count} !== {1'b0, 1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL small_empty r=%0d got valid=%b done=%b count=%0d", r, s_rd_valid, s_done, s_count);
            end
        end
    endtask

    initial begin
        s_rst = 1'b1; s_trig_en = 1'b0; s_rd_ready = 1'b0;
        s_dir = 16'h0; s_pal = 16'h0; s_leer = 16'h0; s_trig_addr = 16'h0;
        test_reset;
        test_capture;
        test_drain;
        test_no_trigger;
        test_reset_mid_capture;
        test_small_build;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
